sram_arbiter: RTL
=================

# sram_arbiter

Multi-cycle arbiter and sequencer that shares the board's two SRAM banks (base and ext) between the CPU's instruction-fetch port and data-memory port. It grants one requester at a time, drives correctly timed CE/OE/WE/BE strobes with a parameterised access length, and returns a one-cycle ack with registered read data. It sits between the openmips core's SRAM-decoded bus ports and the top-level tristate pads, and replaces the combinational address mux.

## Interface
- READ_CYCLES, 2, cycles OE is held low before read data is captured (≥1)
- WE_CYCLES, 2, cycles WE is held low during a write (≥1)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  instruction fetch request, level, held until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  32  fetch data, valid while if_ack=1
- mem_req  in  1  data request, level, held until mem_ack
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  data byte address
- mem_sel  in  4  byte enables, active-high
- mem_wdata  in  32  write data
- mem_ack  out  1  one-cycle completion pulse for data access
- mem_rdata  out  32  read data, valid while mem_ack=1
- stall_o  out  1  CPU stall: (if_req & ~if_ack) | (mem_req & ~mem_ack)
- base_data_i, ext_data_i  in  32  bank pad input data
- ram_data_o  out  32  write data to both banks' pads
- base_data_oe, ext_data_oe  out  1  pad output enable per bank
- base_addr, ext_addr  out  20  word address
- base_be_n, ext_be_n  out  4  byte enables, active-low
- base_ce_n/oe_n/we_n, ext_ce_n/oe_n/we_n  out  1  strobes, active-low

## Operation
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: if mem_req, grant MEM; else if if_req, grant IF; else stay. Grant latches addr, we (IF forces 0), sel (IF forces 4'b1111), wdata, bank = addr[22], port.
- Fixed priority: MEM beats IF when both are asserted in the same IDLE cycle.
- Selected bank only: addr = latched addr[21:2], be_n = ~sel. The unselected bank stays at idle values.
- READ: ce_n=0, oe_n=0, we_n=1 for READ_CYCLES cycles. On the last cycle, the selected bank's data_i is registered into the granted port's rdata. Then DONE.
- WR_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, data_oe=1, ram_data_o = wdata.
- WR_PULSE (WE_CYCLES cycles): same as WR_SETUP but we_n=0.
- WR_HOLD (1 cycle): we_n=1, data_oe and data stay asserted. Then DONE.
- DONE (1 cycle): all strobes at idle values, data_oe=0, granted port's ack=1. Then IDLE.
- data_oe is never 1 while oe_n=0 on the same bank.
- Idle values: ce_n=oe_n=we_n=1, be_n=4'b1111, addr=0, data_oe=0.
- Requests are sampled only in IDLE. Changes to a request's inputs or its deassertion mid-transaction are ignored; the access completes and ack still pulses.
- An internal cycle counter, width sufficient for max(READ_CYCLES, WE_CYCLES), reloads on each state entry.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - All strobes and data_oe at idle values.
  - ram_data_o=0, if_ack=mem_ack=0, if_rdata=mem_rdata=0.
- Reset mid-access releases pads and strobes immediately and drops the transaction; no ack is issued.
- Read latency: request sampled in IDLE at cycle N; READ occupies N+1..N+READ_CYCLES; ack at N+READ_CYCLES+1.
- Write latency: WR_SETUP at N+1; WR_PULSE at N+2..N+1+WE_CYCLES; WR_HOLD at N+2+WE_CYCLES; ack at N+3+WE_CYCLES.
- Back-to-back: IDLE follows DONE, so the next grant happens 1 cycle after ack. Minimum read period is READ_CYCLES+2.
- stall_o is combinational and deasserts in the ack cycle.

## Test plan
- Single IF read at 0x00000010, READ_CYCLES=2, base_data_i=0xDEADBEEF:
  - base_addr=4, base_oe_n=0 for 2 cycles.
  - if_ack pulses exactly at N+3 with if_rdata=0xDEADBEEF.
  - ext strobes stay high throughout.
- MEM write to 0x00400008, sel=4'b0011, wdata=0x12345678, WE_CYCLES=2:
  - ext_addr=2, ext_be_n=4'b1100.
  - ext_we_n low for exactly 2 cycles, bracketed by 1 cycle each of ext_data_oe=1 with we_n=1.
  - mem_ack at N+5.
- Simultaneous if_req and mem_req in IDLE:
  - MEM is served first.
  - IF is granted in the cycle after mem_ack; if_ack follows READ_CYCLES+1 cycles later.
  - stall_o stays high until if_ack.
- mem_addr and mem_wdata changed, and mem_req dropped, during WR_PULSE:
  - Pads keep the originally latched values.
  - mem_ack still pulses.
- rst asserted low during READ:
  - All ce_n/oe_n/we_n=1, data_oe=0, acks=0 within the same cycle.
  - After release, a new if_req completes normally.
- READ_CYCLES=1, WE_CYCLES=1 with continuous if_req:
  - Acks are spaced exactly 3 cycles apart.
  - Each if_rdata matches base_data_i as it was in the last READ cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares the base/ext SRAM banks between the fetch and data ports: one grant at a
// time, strobes sequenced by a small FSM, one-cycle ack with registered read data.
module sram_arbiter #(
    parameter int READ_CYCLES = 2,
    parameter int WE_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        stall_o,
    input  logic [31:0] base_data_i,
    input  logic [31:0] ext_data_i,
    output logic [31:0] ram_data_o,
    output logic        base_data_oe,
    output logic        ext_data_oe,
    output logic [19:0] base_addr,
    output logic [19:0] ext_addr,
    output logic [3:0]  base_be_n,
    output logic [3:0]  ext_be_n,
    output logic        base_ce_n,
    output logic        base_oe_n,
    output logic        base_we_n,
    output logic        ext_ce_n,
    output logic        ext_oe_n,
    output logic        ext_we_n
);
    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

    localparam int MAXC = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [19:0]   r_addr;
    logic          r_we, r_bank, r_port;  // r_port: 1 = data port
    logic [3:0]    r_sel;
    logic [31:0]   r_wdata, r_if_rdata, r_mem_rdata;
    logic          w_cnt_zero, w_act, w_wr, w_base, w_ext;
    logic [31:0]   w_din;
    logic          w_unused;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_unused   = &{1'b0, if_addr[31:23], if_addr[1:0], mem_addr[31:23], mem_addr[1:0], r_we};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (mem_req)     w_next = mem_we ? WR_SETUP : READ;
                      else if (if_req) w_next = READ;
            READ:     if (w_cnt_zero)  w_next = DONE;
            WR_SETUP: w_next = WR_PULSE;
            WR_PULSE: if (w_cnt_zero)  w_next = WR_HOLD;
            WR_HOLD:  w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Counter reloads on every state change; only READ/WR_PULSE consult it.
            if (w_next != r_state)
                r_cnt <= (w_next == WR_PULSE) ? CW'(WE_CYCLES - 1) : CW'(READ_CYCLES - 1);
            else if (!w_cnt_zero)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_sel   <= 4'hF;
            r_wdata <= '0;
            r_bank  <= 1'b0;
            r_port  <= 1'b0;
        end else if (r_state == IDLE && (mem_req || if_req)) begin
            r_port  <= mem_req;
            r_addr  <= mem_req ? mem_addr[21:2] : if_addr[21:2];
            r_bank  <= mem_req ? mem_addr[22]   : if_addr[22];
            r_we    <= mem_req & mem_we;
            r_sel   <= mem_req ? mem_sel : 4'hF;
            r_wdata <= mem_req ? mem_wdata : '0;
        end
    end

    assign w_din = r_bank ? ext_data_i : base_data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else if (r_state == READ && w_cnt_zero) begin
            if (r_port) r_mem_rdata <= w_din;
            else        r_if_rdata  <= w_din;
        end
    end

    assign w_act = (r_state == READ) || w_wr;
    assign w_wr  = (r_state == WR_SETUP) || (r_state == WR_PULSE) || (r_state == WR_HOLD);
    assign w_base = w_act & ~r_bank;
    assign w_ext  = w_act &  r_bank;

    assign base_ce_n    = ~w_base;
    assign base_oe_n    = ~(w_base && r_state == READ);
    assign base_we_n    = ~(w_base && r_state == WR_PULSE);
    assign base_data_oe = w_base & w_wr;
    assign base_addr    = w_base ? r_addr : 20'h0;
    assign base_be_n    = w_base ? ~r_sel : 4'hF;

    assign ext_ce_n     = ~w_ext;
    assign ext_oe_n     = ~(w_ext && r_state == READ);
    assign ext_we_n     = ~(w_ext && r_state == WR_PULSE);
    assign ext_data_oe  = w_ext & w_wr;
    assign ext_addr     = w_ext ? r_addr : 20'h0;
    assign ext_be_n     = w_ext ? ~r_sel : 4'hF;

    assign ram_data_o = w_wr ? r_wdata : 32'h0;
    assign if_ack     = (r_state == DONE) & ~r_port;
    assign mem_ack    = (r_state == DONE) &  r_port;
    assign if_rdata   = r_if_rdata;
    assign mem_rdata  = r_mem_rdata;
    assign stall_o    = (if_req & ~if_ack) | (mem_req & ~mem_ack);
endmodule
